// File: rtl/decode_stage.sv
// decode_stage: ID stage of a MIPS-style pipeline.
// Decodes the fetched instruction and returns jump/branch targets to fetch
// in the same cycle. Detects load-use hazards and registers the decoded
// fields into the ID/EX register. HLT drives a sticky halted state.
module decode_stage #(
  parameter int         XLEN       = 32,
  parameter logic [5:0] HLT_OPCODE = 6'b111111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] PC4_f,
  input  logic [XLEN-1:0] rd1_data,
  input  logic [XLEN-1:0] rd2_data,
  input  logic            wrong,
  output logic            stall_fetch_now,
  output logic            jump,
  output logic            jump_r,
  output logic [XLEN-1:0] NPC4_jr,
  output logic [XLEN-1:0] branch,
  output logic            hlt,
  output logic            ex_valid,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc4,
  output logic [2:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_is_branch,
  output logic            ex_bne
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc4;
    logic [2:0]      aluOp;
    logic            aluSrc;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic            isBranch;
    logic            bne;
  } idex_t;

  state_t r_state;
  logic   r_hlt;
  idex_t  r_idEx;

  logic [5:0]      w_opcode;
  logic [5:0]      w_funct;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rdField;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_jTarget;
  logic [XLEN-1:0] w_bTarget;

  logic       w_isAluR;
  logic [2:0] w_rAluOp;
  logic       w_isJr;
  logic       w_isLw;
  logic       w_isSw;
  logic       w_isBeq;
  logic       w_isBne;
  logic       w_isAddi;
  logic       w_isJ;
  logic       w_isJal;
  logic       w_isHlt;
  logic       w_isValid;
  logic       w_readsRs;
  logic       w_readsRt;
  logic       w_hazard;
  logic       w_gate;
  idex_t      w_dec;

  assign w_opcode  = instruction[31:26];
  assign w_rs      = instruction[25:21];
  assign w_rt      = instruction[20:16];
  assign w_rdField = instruction[15:11];
  assign w_funct   = instruction[5:0];
  assign w_imm     = {{(XLEN-16){instruction[15]}}, instruction[15:0]};
  assign w_jTarget = {PC4_f[31:28], instruction[25:0], 2'b00};
  assign w_bTarget = PC4_f + (w_imm << 2);
  assign w_isHlt   = (w_opcode == HLT_OPCODE);

  // Classify the instruction; unrecognised encodings leave every flag low (NOP)
  always_comb begin
    w_isAluR = 1'b0;
    w_rAluOp = 3'b000;
    w_isJr   = 1'b0;
    w_isLw   = 1'b0;
    w_isSw   = 1'b0;
    w_isBeq  = 1'b0;
    w_isBne  = 1'b0;
    w_isAddi = 1'b0;
    w_isJ    = 1'b0;
    w_isJal  = 1'b0;
    case (w_opcode)
      6'b000000: begin
        case (w_funct)
          6'b100000: begin w_isAluR = 1'b1; w_rAluOp = 3'b000; end
          6'b100010: begin w_isAluR = 1'b1; w_rAluOp = 3'b001; end
          6'b100100: begin w_isAluR = 1'b1; w_rAluOp = 3'b010; end
          6'b100101: begin w_isAluR = 1'b1; w_rAluOp = 3'b011; end
          6'b101010: begin w_isAluR = 1'b1; w_rAluOp = 3'b100; end
          6'b001000: w_isJr = 1'b1;
          default:   ;
        endcase
      end
      6'b100011: w_isLw   = 1'b1;
      6'b101011: w_isSw   = 1'b1;
      6'b000100: w_isBeq  = 1'b1;
      6'b000101: w_isBne  = 1'b1;
      6'b001000: w_isAddi = 1'b1;
      6'b000010: w_isJ    = 1'b1;
      6'b000011: w_isJal  = 1'b1;
      default:   ;
    endcase
  end

  assign w_isValid = w_isAluR | w_isJr | w_isLw | w_isSw | w_isBeq | w_isBne |
                     w_isAddi | w_isJ | w_isJal;
  assign w_readsRs = w_isAluR | w_isJr | w_isLw | w_isSw | w_isBeq | w_isBne | w_isAddi;
  assign w_readsRt = w_isAluR | w_isJr | w_isSw | w_isBeq | w_isBne;

  // Build the ID/EX contents the current instruction would load
  always_comb begin
    w_dec = '0;
    if (w_isValid) begin
      w_dec.valid    = 1'b1;
      w_dec.imm      = w_imm;
      w_dec.pc4      = PC4_f;
      w_dec.memRead  = w_isLw;
      w_dec.memWrite = w_isSw;
      w_dec.bne      = w_isBne;
      if (w_isJal) begin
        w_dec.a        = PC4_f;
        w_dec.rd       = 5'd31;
        w_dec.regWrite = 1'b1;
      end else if (!w_isJ) begin
        w_dec.rs = w_rs;
        w_dec.rt = w_rt;
        w_dec.a  = rd1_data;
        w_dec.b  = rd2_data;
      end
      if (w_isAluR) begin
        w_dec.rd       = w_rdField;
        w_dec.aluOp    = w_rAluOp;
        w_dec.regWrite = 1'b1;
      end
      if (w_isLw || w_isAddi) begin
        w_dec.rd       = w_rt;
        w_dec.aluSrc   = 1'b1;
        w_dec.regWrite = 1'b1;
      end
      if (w_isSw) begin
        w_dec.aluSrc = 1'b1;
      end
      if (w_isBeq || w_isBne) begin
        w_dec.aluOp    = 3'b001;
        w_dec.isBranch = 1'b1;
      end
    end
  end

  // A load in EX whose target feeds this instruction forces one bubble
  assign w_hazard = (r_state == RUN) && r_idEx.valid && r_idEx.memRead &&
                    (r_idEx.rt != 5'd0) &&
                    ((w_readsRs && (r_idEx.rt == w_rs)) ||
                     (w_readsRt && (r_idEx.rt == w_rt)));

  assign w_gate          = wrong || (r_state == HALT);
  assign stall_fetch_now = w_hazard && !w_gate;
  assign jump            = (w_isJ || w_isJal) && !w_gate;
  assign jump_r          = w_isJr && !w_gate;
  assign NPC4_jr         = rd1_data;

  // Redirect target for fetch; zero for anything that is not a jump or branch
  always_comb begin
    branch = '0;
    if (!w_gate) begin
      if (w_isJ || w_isJal) begin
        branch = w_jTarget;
      end else if (w_isBeq || w_isBne) begin
        branch = w_bTarget;
      end
    end
  end

  // Pipeline control: flush, halt, hazard bubble or normal load, in that priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_hlt   <= 1'b0;
      r_idEx  <= '0;
    end else if (wrong) begin
      r_idEx <= '0;
      if (r_state != HALT) begin
        r_state <= RUN;
      end
    end else if (r_state == HALT) begin
      r_idEx <= '0;
    end else if (w_isHlt) begin
      r_idEx  <= '0;
      r_state <= HALT;
      r_hlt   <= 1'b1;
    end else if (w_hazard) begin
      r_idEx  <= '0;
      r_state <= STALL;
    end else begin
      r_idEx  <= w_dec;
      r_state <= RUN;
    end
  end

  assign hlt          = r_hlt;
  assign ex_valid     = r_idEx.valid;
  assign ex_rs        = r_idEx.rs;
  assign ex_rt        = r_idEx.rt;
  assign ex_rd        = r_idEx.rd;
  assign ex_a         = r_idEx.a;
  assign ex_b         = r_idEx.b;
  assign ex_imm       = r_idEx.imm;
  assign ex_pc4       = r_idEx.pc4;
  assign ex_alu_op    = r_idEx.aluOp;
  assign ex_alu_src   = r_idEx.aluSrc;
  assign ex_reg_write = r_idEx.regWrite;
  assign ex_mem_read  = r_idEx.memRead;
  assign ex_mem_write = r_idEx.memWrite;
  assign ex_is_branch = r_idEx.isBranch;
  assign ex_bne       = r_idEx.bne;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by random traffic.
// A mnemonic-level reference model predicts the fetch-facing outputs each
// cycle and queues the expected ID/EX contents for a separate monitor.
module tb_decode_stage;

  typedef enum {M_NOP, M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_JR, M_LW, M_SW,
                M_BEQ, M_BNE, M_ADDI, M_J, M_JAL, M_HLT} mnem_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [2:0]  aluOp;
    logic        aluSrc;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        isBranch;
    logic        bne;
  } exRec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] PC4_f;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic        wrong;
  logic        stall_fetch_now, jump, jump_r, hlt;
  logic [31:0] NPC4_jr, branch;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_bne;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;
  bit done = 1'b0;

  exRec_t expQ[$];
  exRec_t mEx;
  bit     mHalted;
  bit     lastStall;

  decode_stage dut (
    .clk(clk), .reset(reset), .instruction(instruction), .PC4_f(PC4_f),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .wrong(wrong),
    .stall_fetch_now(stall_fetch_now), .jump(jump), .jump_r(jump_r),
    .NPC4_jr(NPC4_jr), .branch(branch), .hlt(hlt),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_is_branch(ex_is_branch), .ex_bne(ex_bne)
  );

  always #5 clk = ~clk;

  function automatic mnem_t classify(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: case (fn)
               6'h20: return M_ADD;
               6'h22: return M_SUB;
               6'h24: return M_AND;
               6'h25: return M_OR;
               6'h2a: return M_SLT;
               6'h08: return M_JR;
               default: return M_NOP;
             endcase
      6'h23: return M_LW;
      6'h2b: return M_SW;
      6'h04: return M_BEQ;
      6'h05: return M_BNE;
      6'h08: return M_ADDI;
      6'h02: return M_J;
      6'h03: return M_JAL;
      6'h3f: return M_HLT;
      default: return M_NOP;
    endcase
  endfunction

  function automatic exRec_t expectedEx(input mnem_t m, input logic [31:0] ins,
                                        input logic [31:0] pc4, input logic [31:0] a1,
                                        input logic [31:0] a2);
    exRec_t r;
    r = '0;
    if (m == M_NOP || m == M_HLT) return r;
    r.valid = 1'b1;
    r.imm   = {{16{ins[15]}}, ins[15:0]};
    r.pc4   = pc4;
    if (m != M_J && m != M_JAL) begin
      r.rs = ins[25:21];
      r.rt = ins[20:16];
      r.a  = a1;
      r.b  = a2;
    end
    case (m)
      M_ADD: begin r.rd = ins[15:11]; r.aluOp = 3'd0; r.regWrite = 1'b1; end
      M_SUB: begin r.rd = ins[15:11]; r.aluOp = 3'd1; r.regWrite = 1'b1; end
      M_AND: begin r.rd = ins[15:11]; r.aluOp = 3'd2; r.regWrite = 1'b1; end
      M_OR:  begin r.rd = ins[15:11]; r.aluOp = 3'd3; r.regWrite = 1'b1; end
      M_SLT: begin r.rd = ins[15:11]; r.aluOp = 3'd4; r.regWrite = 1'b1; end
      M_LW:  begin r.rd = ins[20:16]; r.aluSrc = 1'b1; r.regWrite = 1'b1; r.memRead = 1'b1; end
      M_SW:  begin r.aluSrc = 1'b1; r.memWrite = 1'b1; end
      M_BEQ: begin r.aluOp = 3'd1; r.isBranch = 1'b1; end
      M_BNE: begin r.aluOp = 3'd1; r.isBranch = 1'b1; r.bne = 1'b1; end
      M_ADDI: begin r.rd = ins[20:16]; r.aluSrc = 1'b1; r.regWrite = 1'b1; end
      M_JAL: begin r.a = pc4; r.rd = 5'd31; r.regWrite = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // One fetch cycle: drive inputs, predict and check fetch-facing outputs, queue ID/EX
  task automatic applyStimulus(input logic rstN, input logic [31:0] ins, input logic [31:0] pc4,
                               input logic [31:0] a1, input logic [31:0] a2, input logic wr);
    mnem_t       m;
    bit          gate, haz, usesRs, usesRt;
    logic [31:0] expBranch, sx;
    exRec_t      nxt;
    @(negedge clk);
    reset = rstN; instruction = ins; PC4_f = pc4; rd1_data = a1; rd2_data = a2; wrong = wr;
    started = 1'b1;
    if (!rstN) begin
      mEx = '0;
      mHalted = 1'b0;
    end
    #1;
    m = classify(ins);
    sx = {{16{ins[15]}}, ins[15:0]};
    gate = wr || mHalted;
    usesRs = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_JR, M_LW, M_SW, M_BEQ, M_BNE, M_ADDI};
    usesRt = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_JR, M_SW, M_BEQ, M_BNE};
    haz = !gate && mEx.valid && mEx.memRead && (mEx.rt != 0) &&
          ((usesRs && mEx.rt == ins[25:21]) || (usesRt && mEx.rt == ins[20:16]));
    expBranch = 32'h0;
    if (!gate && (m == M_J || m == M_JAL)) expBranch = {pc4[31:28], ins[25:0], 2'b00};
    if (!gate && (m == M_BEQ || m == M_BNE)) expBranch = pc4 + sx * 4;
    checkOutput("stall_fetch_now", {31'b0, stall_fetch_now}, {31'b0, haz});
    checkOutput("jump", {31'b0, jump}, {31'b0, !gate && (m == M_J || m == M_JAL)});
    checkOutput("jump_r", {31'b0, jump_r}, {31'b0, !gate && (m == M_JR)});
    checkOutput("NPC4_jr", NPC4_jr, a1);
    checkOutput("branch", branch, expBranch);
    checkOutput("hlt", {31'b0, hlt}, {31'b0, mHalted});
    lastStall = haz;
    nxt = '0;
    if (!rstN) nxt = '0;
    else if (wr) nxt = '0;
    else if (mHalted) nxt = '0;
    else if (m == M_HLT) mHalted = 1'b1;
    else if (haz) nxt = '0;
    else nxt = expectedEx(m, ins, pc4, a1, a2);
    mEx = nxt;
    expQ.push_back(nxt);
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fn;
    int          k;
    int          f;
    rs  = 5'($urandom_range(0, 4));
    rt  = 5'($urandom_range(0, 4));
    rd  = 5'($urandom_range(0, 4));
    imm = 16'($urandom);
    k   = $urandom_range(0, 15);
    case (k)
      0: return 32'h0;
      1: return {6'b010001, 10'b0, imm};
      2, 3, 4, 5, 6: begin
        f = $urandom_range(0, 4);
        case (f)
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h24;
          3: fn = 6'h25;
          default: fn = 6'h2a;
        endcase
        return {6'h00, rs, rt, rd, 5'b0, fn};
      end
      7:  return {6'h00, rs, 15'b0, 6'h08};
      8:  return {6'h23, rs, rt, imm};
      9:  return {6'h2b, rs, rt, imm};
      10: return {6'h04, rs, rt, imm};
      11: return {6'h05, rs, rt, imm};
      12: return {6'h08, rs, rt, imm};
      13: return {6'h02, 26'($urandom)};
      14: return {6'h03, 26'($urandom)};
      default: return ($urandom_range(0, 3) == 0) ? 32'hFC000000 : {6'h00, rs, rt, rd, 5'b0, 6'h20};
    endcase
  endfunction

  // Monitor: every edge the ID/EX register must match the oldest queued prediction
  initial begin : monitor
    exRec_t exp;
    exRec_t got;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        got = {ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_pc4, ex_alu_op,
               ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_bne};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL idex: got=%h expected=%h at %0t", got, exp, $time);
        end
      end else if (started && !done) begin
        checks++;
        errors++;
        $display("[TB] FAIL idex_queue: got=empty expected=entry at %0t", $time);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] curInstr;
    logic [31:0] pc;
    bit          hold;
    reset = 1'b0; instruction = 32'h0; PC4_f = 32'h0; rd1_data = 32'h0; rd2_data = 32'h0; wrong = 1'b0;
    mEx = '0; mHalted = 1'b0; lastStall = 1'b0;

    // Reset held with addi $8,$0,5 present, then released
    applyStimulus(1'b0, 32'h20080005, 32'h4, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h20080005, 32'h4, 32'h0, 32'h0, 1'b0);
    checkOutput("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
    applyStimulus(1'b1, 32'h20080005, 32'h4, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    checkOutput("addi_rd", {27'b0, ex_rd}, 32'd8);
    checkOutput("addi_imm", ex_imm, 32'd5);
    checkOutput("addi_ctrl", {29'b0, ex_valid, ex_alu_src, ex_reg_write}, 32'h7);

    // Load-use: lw $9,0($8) then add $10,$9,$9 held for the stall
    applyStimulus(1'b1, 32'h8D090000, 32'h8, 32'h5, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h01295020, 32'hC, 32'h0, 32'h0, 1'b0);
    checkOutput("lu_stall_on", {31'b0, stall_fetch_now}, 32'h1);
    applyStimulus(1'b1, 32'h01295020, 32'hC, 32'h7, 32'h7, 1'b0);
    checkOutput("lu_stall_off", {31'b0, stall_fetch_now}, 32'h0);
    @(posedge clk); #1;
    checkOutput("lu_add_rs", {27'b0, ex_rs}, 32'd9);

    // j 0x40 and beq with a negative offset
    applyStimulus(1'b1, 32'h08000040, 32'h00400008, 32'h0, 32'h0, 1'b0);
    checkOutput("j_jump", {31'b0, jump}, 32'h1);
    checkOutput("j_target", branch, 32'h00000100);
    applyStimulus(1'b1, 32'h1000FFFE, 32'h00000100, 32'h0, 32'h0, 1'b0);
    checkOutput("beq_target", branch, 32'h000000F8);
    @(posedge clk); #1;
    checkOutput("beq_is_branch", {31'b0, ex_is_branch}, 32'h1);

    // jr $31, then the same with a flush from EX
    applyStimulus(1'b1, 32'h03E00008, 32'h104, 32'h1234, 32'h0, 1'b0);
    checkOutput("jr_jump_r", {31'b0, jump_r}, 32'h1);
    checkOutput("jr_target", NPC4_jr, 32'h1234);
    applyStimulus(1'b1, 32'h03E00008, 32'h104, 32'h1234, 32'h0, 1'b1);
    checkOutput("jr_wrong_jump_r", {31'b0, jump_r}, 32'h0);
    @(posedge clk); #1;
    checkOutput("jr_wrong_bubble", {31'b0, ex_valid}, 32'h0);

    // HLT, a following add is bubbled, then reset clears the halt
    applyStimulus(1'b1, 32'hFC000000, 32'h108, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h01295020, 32'h10C, 32'h1, 32'h2, 1'b0);
    checkOutput("halt_flag", {31'b0, hlt}, 32'h1);
    @(posedge clk); #1;
    checkOutput("halt_bubble", {31'b0, ex_valid}, 32'h0);
    applyStimulus(1'b0, 32'h01295020, 32'h10C, 32'h1, 32'h2, 1'b0);
    checkOutput("halt_reset", {31'b0, hlt}, 32'h0);
    applyStimulus(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Random traffic; fetch holds the instruction whenever a stall is expected
    pc = 32'h00400000;
    hold = 1'b0;
    curInstr = 32'h0;
    for (int n = 0; n < 600; n++) begin
      logic rstN;
      logic wr;
      if (!hold) curInstr = randInstr();
      rstN = ($urandom_range(0, 59) != 0);
      wr   = ($urandom_range(0, 9) == 0);
      applyStimulus(rstN, curInstr, pc, $urandom, $urandom, wr);
      hold = lastStall;
      if (!lastStall) pc = pc + 32'd4;
    end
    done = 1'b1;
    @(posedge clk); #3;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL idex_drain: got=%0d expected=0 entries", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage directly downstream of the instruction fetch stage.
- Consumes the registered fetch instruction and its PC+4, and decodes the MIPS-style 32-bit instruction.
- Returns jump, jump-register and branch-target information to fetch in the same cycle, and detects load-use hazards (drives the fetch stall).
- Registers the decoded fields into an ID/EX pipeline register, and latches HLT into a sticky halted state.

Parameters:
- XLEN, 32, datapath / instruction width
- HLT_OPCODE, 6'b111111, opcode of halt instruction

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- instruction  input  32  instruction from fetch pipeline register (32'b0 = NOP bubble)
- PC4_f  input  32  PC+4 of instruction
- rd1_data  input  32  register-file read data for rs
- rd2_data  input  32  register-file read data for rt
- wrong  input  1  branch mispredict flush from EX
- stall_fetch_now  output  1  combinational load-use stall request to fetch
- jump  output  1  combinational: current instr is j/jal
- jump_r  output  1  combinational: current instr is jr
- NPC4_jr  output  32  combinational jr target = rd1_data
- branch  output  32  combinational jump/branch target
- hlt  output  1  registered sticky halt flag
- ex_valid  output  1  ID/EX register holds a real instruction
- ex_rs, ex_rt, ex_rd  output  5 each  registered source/destination register numbers
- ex_a, ex_b, ex_imm  output  32 each  registered operand A, operand B, sign-extended immediate
- ex_pc4  output  32  registered PC+4
- ex_alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- ex_alu_src  output  1  1 = immediate operand
- ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_bne  output  1 each  registered control

Behaviour:
- Decode set:
  - R-type opcode 000000, funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
  - I-type: lw 100011, sw 101011, beq 000100, bne 000101, addi 001000.
  - J-type: j 000010, jal 000011.
  - HLT_OPCODE.
  - Any other encoding decodes as NOP (all controls 0, ex_valid 0).
- Destination:
  - R-type uses rd.
  - addi/lw use rt.
  - jal writes 31 with ex_a = PC4_f.
  - No destination otherwise.
- Immediate: sign-extended [15:0].
- branch output:
  - j/jal: {PC4_f[31:28], instr[25:0], 2'b00}.
  - beq/bne: PC4_f + (imm << 2).
  - Otherwise 0.
- Load-use hazard is asserted when all hold:
  - ex_mem_read = 1 and ex_valid = 1;
  - ex_rt != 0;
  - ex_rt equals the current rs (all non-J instructions), or equals the current rt for R-type, sw, beq or bne.
- States: RUN, STALL, HALT.
  - RUN → STALL on hazard. During that cycle stall_fetch_now = 1, and the ID/EX register loads a bubble (all fields 0).
  - STALL → RUN next cycle. stall_fetch_now = 0; the held instruction now decodes normally. At most one stall cycle per hazard.
  - RUN → HALT when a valid HLT decodes. hlt = 1 from the next edge; the HLT itself enters ID/EX as a bubble.
  - HALT is sticky until reset. Every subsequent instruction loads as a bubble; jump, jump_r and stall_fetch_now are forced 0.
- jump, jump_r, branch and stall_fetch_now are gated to 0 when wrong = 1 or the state is HALT.
- Priority per edge: reset > wrong > HALT > hazard > normal load.
  - wrong = 1 loads a bubble and returns STALL → RUN.
  - wrong does not clear HALT.
- Reset (reset = 0, async):
  - All ID/EX outputs 0, hlt 0, state RUN.
  - Combinational outputs follow the decode of the current instruction (0 for a NOP).
  - Reset mid-stall aborts the stall.
- Latency: one clock from instruction to ex_* outputs.
- Register r0 as a destination is written through unchanged; EX/WB ignore it.
- No arithmetic overflow detection.

Test Plan:
- Reset low with instruction = 0x20080005 (addi $8,$0,5), then release → first edge: ex_valid = 1, ex_rd = 8, ex_imm = 5, ex_alu_src = 1, ex_reg_write = 1; while reset is low all ex_* = 0.
- lw $9,0($8) followed by add $10,$9,$9 → stall_fetch_now = 1 for exactly one cycle, bubble appears in ID/EX, then the add issues with ex_rs = 9.
- j 0x0000040 with PC4_f = 0x00400008 → jump = 1, branch = 0x00000100, same cycle.
- beq with imm = -2 (0xFFFE), PC4_f = 0x100 → branch = 0x000000F8, ex_is_branch = 1 next cycle.
- jr $31 with rd1_data = 0x1234 → jump_r = 1, NPC4_jr = 0x1234; same stimulus with wrong = 1 → jump_r = 0 and bubble loaded.
- HLT (0xFC000000), then add, then reset pulse → hlt = 1 from the next edge, add is bubbled (ex_valid = 0), and after reset hlt = 0.
